// File: rtl/uart_bus_master_pkg.sv
// Shared types and constants for the UART strobe-interface bus master.
package uart_bus_master_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned GUARD_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    GUARD
  } state_t;

  typedef struct packed {
    logic [1:0]        err;   // {framing, parity}
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_bus_master_fifo.sv
// Synchronous show-ahead FIFO for received bytes and their error flags.
module uart_bus_master_fifo
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RESET_N,
  input  logic      push,
  input  rx_entry_t push_data,
  input  logic      pop,
  output rx_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rx_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // Empty FIFO presents zeros so the user-side outputs are clean after reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART CPU-side strobe initiator with TX holding register and RX FIFO.
// Optional saturating error counter: define UART_BUS_MASTER_ERRCNT_EN.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned RX_DEPTH     = 4,
  parameter int unsigned GUARD_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic              CSN,
  output logic              WEN,
  output logic              OEN,
  output logic [BYTE_W-1:0] DATA_OUT,
  input  logic [BYTE_W-1:0] DATA_IN,
  input  logic              TXRDY,
  input  logic              RXRDY,
  input  logic              PARITY_ERR,
  input  logic              FRAMING_ERR,
  input  logic              OVERFLOW,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  output logic [1:0]        rx_err,
  input  logic              rx_ready,
  output logic              ovf_sticky,
  input  logic              clr_ovf,
  output logic [7:0]        err_count
);

  state_t             state;
  logic [GUARD_W-1:0] guard_cnt;
  logic               hold_full;
  logic [BYTE_W-1:0]  hold_data;
  logic               init_done;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  rx_entry_t          push_data;
  rx_entry_t          head;
  logic               rd_req;
  logic               wr_req;

  assign rd_req    = RXRDY && !fifo_full;
  assign wr_req    = hold_full && TXRDY;
  assign push      = (state == RD);
  assign push_data = '{err: {FRAMING_ERR, PARITY_ERR}, data: DATA_IN};
  assign tx_ready  = init_done && !hold_full;
  assign rx_valid  = !fifo_empty;
  assign rx_data   = head.data;
  assign rx_err    = head.err;

  uart_bus_master_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .push      (push),
    .push_data (push_data),
    .pop       (rx_valid && rx_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      CSN       <= 1'b1;
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      DATA_OUT  <= '0;
      guard_cnt <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (tx_valid && tx_ready) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end
      case (state)
        // The last guard cycle makes the IDLE decision itself so strobes
        // repeat every GUARD_CYCLES+1 cycles despite the registered outputs.
        IDLE, GUARD: begin
          if (state == GUARD && guard_cnt != '0) begin
            guard_cnt <= guard_cnt - 1'b1;
          end else if (rd_req) begin
            state <= RD;
            CSN   <= 1'b0;
            OEN   <= 1'b0;
          end else if (wr_req) begin
            state    <= WR;
            CSN      <= 1'b0;
            WEN      <= 1'b0;
            DATA_OUT <= hold_data;
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          CSN       <= 1'b1;
          OEN       <= 1'b1;
          state     <= GUARD;
          guard_cnt <= GUARD_W'(GUARD_CYCLES - 1);
        end
        WR: begin
          CSN       <= 1'b1;
          WEN       <= 1'b1;
          hold_full <= 1'b0;
          state     <= GUARD;
          guard_cnt <= GUARD_W'(GUARD_CYCLES - 1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N)      ovf_sticky <= 1'b0;
    else if (OVERFLOW) ovf_sticky <= 1'b1;
    else if (clr_ovf)  ovf_sticky <= 1'b0;
  end

`ifdef UART_BUS_MASTER_ERRCNT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N || clr_ovf)
      err_count <= '0;
    else if (push && (FRAMING_ERR || PARITY_ERR) && err_count != 8'hFF)
      err_count <= err_count + 1'b1;
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed self-checking bench for uart_bus_master with a small UART status model.
module tb_uart_bus_master;

`ifdef UART_BUS_MASTER_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CSN, WEN, OEN;
  logic [7:0] DATA_OUT;
  logic [7:0] DATA_IN = '0;
  logic       TXRDY = 1'b0;
  logic       RXRDY = 1'b0;
  logic       PARITY_ERR = 1'b0, FRAMING_ERR = 1'b0;
  logic       OVERFLOW = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [1:0] rx_err;
  logic       rx_ready = 1'b0;
  logic       ovf_sticky;
  logic       clr_ovf = 1'b0;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_fail = 0;

  uart_bus_master #(.RX_DEPTH(4), .GUARD_CYCLES(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CSN(CSN), .WEN(WEN), .OEN(OEN),
    .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .TXRDY(TXRDY), .RXRDY(RXRDY),
    .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready),
    .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  // UART receive side: queue of {framing, parity, data}; a byte leaves the
  // queue on the negedge after the read strobe that consumed it.
  logic [9:0] uq[$];
  logic [9:0] tmp;
  bit         pop_pending = 0;
  always @(negedge CLK) begin
    if (pop_pending) begin
      tmp = uq.pop_front();
      pop_pending = 0;
    end
    if (!OEN && !CSN) pop_pending = 1;
    RXRDY = (uq.size() > (pop_pending ? 1 : 0));
    {FRAMING_ERR, PARITY_ERR, DATA_IN} = (uq.size() > 0) ? uq[0] : 10'h0;
  end

  // Strobe monitor
  int         cyc = 0;
  int         rd_cnt = 0, wr_cnt = 0, proto_err = 0, long_strobe = 0;
  int         last_cyc = 0, last_gap = -1;
  bit         have_last = 0, prev_strobe = 0;
  logic [7:0] slog[$];
  logic [7:0] wr_q[$];
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (!OEN || !WEN) begin
      if (!OEN) begin rd_cnt++; slog.push_back(8'h52); end
      if (!WEN) begin wr_cnt++; slog.push_back(8'h57); wr_q.push_back(DATA_OUT); end
      if (CSN || (!OEN && !WEN)) proto_err++;
      if (prev_strobe) long_strobe++;
      if (have_last) last_gap = cyc - last_cyc - 1;
      have_last = 1;
      last_cyc = cyc;
    end
    prev_strobe = !OEN || !WEN;
  end

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++; if (CSN !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %b expected 1", CSN); end
    n_cmp++; if (WEN !== 1'b1) begin n_fail++; $display("FAIL reset_wen: got %b expected 1", WEN); end
    n_cmp++; if (OEN !== 1'b1) begin n_fail++; $display("FAIL reset_oen: got %b expected 1", OEN); end
    n_cmp++; if (DATA_OUT !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", DATA_OUT); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00 || rx_err !== 2'b00) begin n_fail++; $display("FAIL reset_rx_data: got %h/%b expected 00/00", rx_data, rx_err); end
    n_cmp++; if (ovf_sticky !== 1'b0 || err_count !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got ovf=%b cnt=%0d expected 0/0", ovf_sticky, err_count); end
    RESET_N = 1'b1;
    @(negedge CLK); #1;
    n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready_rise: got %b expected 1", tx_ready); end
  endtask

  task automatic test_single_rx();
    bit found = 0;
    uq.push_back({2'b00, 8'hA5});
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge CLK); #1;
      if (!OEN) found = 1;
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rx_strobe: no OEN within 30 cycles, expected one"); end
    n_cmp++; if (rx_valid !== 1'b0 || CSN !== 1'b0) begin n_fail++; $display("FAIL rx_during_strobe: got valid=%b csn=%b expected 0/0", rx_valid, CSN); end
    @(negedge CLK); #1;
    n_cmp++; if (OEN !== 1'b1) begin n_fail++; $display("FAIL rx_strobe_len: got OEN=%b expected 1", OEN); end
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || rx_err !== 2'b00) begin
      n_fail++; $display("FAIL rx_data: got v=%b d=%h e=%b expected 1/a5/00", rx_valid, rx_data, rx_err); end
    rx_ready = 1'b1;
    @(negedge CLK); #1;
    rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_pop: got valid=%b expected 0", rx_valid); end
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_single_tx();
    bit found = 0;
    TXRDY = 1'b1;
    wr_q.delete();
    #1;
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge CLK); #1;
    tx_valid = 1'b0;
    n_cmp++; if (tx_ready !== 1'b0 || WEN !== 1'b1) begin n_fail++; $display("FAIL tx_accept: got ready=%b wen=%b expected 0/1", tx_ready, WEN); end
    @(negedge CLK); #1;
    n_cmp++; if (WEN !== 1'b0 || CSN !== 1'b0 || DATA_OUT !== 8'h3C) begin
      n_fail++; $display("FAIL tx_strobe: got wen=%b csn=%b d=%h expected 0/0/3c", WEN, CSN, DATA_OUT); end
    @(negedge CLK); #1;
    n_cmp++; if (WEN !== 1'b1 || tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_after: got wen=%b ready=%b expected 1/1", WEN, tx_ready); end
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge CLK); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK); #1;
      if (!WEN) found = 1;
    end
    n_cmp++; if (!found || last_gap !== 3) begin n_fail++; $display("FAIL tx_gap: got found=%b gap=%0d expected 1/3", found, last_gap); end
    n_cmp++; if (wr_q.size() !== 2 || wr_q[0] !== 8'h3C || wr_q[1] !== 8'h5A) begin
      n_fail++; $display("FAIL tx_bytes: got n=%0d expected 2 bytes 3c,5a", wr_q.size()); end
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_contention();
    TXRDY = 1'b0;
    tx_data = 8'h77; tx_valid = 1'b1;
    @(negedge CLK); #1;
    tx_valid = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    slog.delete(); wr_q.delete();
    uq.push_back({2'b00, 8'h42});
    @(negedge CLK); #1;
    TXRDY = 1'b1;
    repeat (12) @(negedge CLK);
    #1;
    n_cmp++; if (slog.size() !== 2 || slog[0] !== 8'h52 || slog[1] !== 8'h57) begin
      n_fail++; $display("FAIL contention_order: got n=%0d first=%h expected R then W", slog.size(), (slog.size() > 0) ? slog[0] : 8'h00); end
    n_cmp++; if (last_gap !== 3) begin n_fail++; $display("FAIL contention_gap: got %0d expected 3", last_gap); end
    n_cmp++; if (rx_data !== 8'h42 || wr_q.size() !== 1 || wr_q[0] !== 8'h77) begin
      n_fail++; $display("FAIL contention_data: got rx=%h wr_n=%0d expected 42 and one write of 77", rx_data, wr_q.size()); end
    rx_ready = 1'b1;
    @(negedge CLK); #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    int base = rd_cnt;
    for (int i = 0; i < 5; i++) uq.push_back({2'b00, 8'(8'h10 + i)});
    repeat (40) @(negedge CLK);
    #1;
    n_cmp++; if (rd_cnt - base !== 4) begin n_fail++; $display("FAIL fifo_full_reads: got %0d expected 4", rd_cnt - base); end
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h10) begin n_fail++; $display("FAIL fifo_head: got v=%b d=%h expected 1/10", rx_valid, rx_data); end
    rx_ready = 1'b1;
    @(negedge CLK); #1;
    rx_ready = 1'b0;
    repeat (10) @(negedge CLK);
    #1;
    n_cmp++; if (rd_cnt - base !== 5) begin n_fail++; $display("FAIL fifo_fifth_read: got %0d expected 5", rd_cnt - base); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL fifo_order[%0d]: got v=%b d=%h expected 1/%h", i, rx_valid, rx_data, 8'(8'h10 + i)); end
      rx_ready = 1'b1;
      @(negedge CLK); #1;
      rx_ready = 1'b0;
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_drained: got valid=%b expected 0", rx_valid); end
  endtask

  task automatic test_errors();
    uq.push_back({2'b01, 8'h11});
    uq.push_back({2'b10, 8'h22});
    repeat (12) @(negedge CLK);
    #1;
    n_cmp++; if (rx_data !== 8'h11 || rx_err !== 2'b01) begin n_fail++; $display("FAIL err_parity: got d=%h e=%b expected 11/01", rx_data, rx_err); end
    n_cmp++; if (err_count !== (ERRCNT ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL err_count: got %0d expected %0d", err_count, ERRCNT ? 2 : 0); end
    rx_ready = 1'b1;
    @(negedge CLK); #1;
    rx_ready = 1'b0;
    n_cmp++; if (rx_data !== 8'h22 || rx_err !== 2'b10) begin n_fail++; $display("FAIL err_framing: got d=%h e=%b expected 22/10", rx_data, rx_err); end
    rx_ready = 1'b1;
    @(negedge CLK); #1;
    rx_ready = 1'b0;
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got %b expected 0", ovf_sticky); end
    OVERFLOW = 1'b1;
    @(negedge CLK); #1;
    OVERFLOW = 1'b0;
    n_cmp++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf_sticky); end
    repeat (2) @(negedge CLK);
    #1;
    OVERFLOW = 1'b1; clr_ovf = 1'b1;
    @(negedge CLK); #1;
    OVERFLOW = 1'b0;
    n_cmp++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", ovf_sticky); end
    @(negedge CLK); #1;
    clr_ovf = 1'b0;
    n_cmp++; if (ovf_sticky !== 1'b0 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL ovf_clear: got ovf=%b cnt=%0d expected 0/0", ovf_sticky, err_count); end
  endtask

  task automatic test_reset_in_wr();
    bit found = 0;
    int wr_base;
    TXRDY = 1'b1;
    tx_data = 8'h99; tx_valid = 1'b1;
    @(negedge CLK); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!WEN) found = 1;
      else begin @(negedge CLK); #1; end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rstwr_strobe: no WEN within 20 cycles, expected one"); end
    RESET_N = 1'b0;
    @(negedge CLK); #1;
    n_cmp++; if (WEN !== 1'b1 || CSN !== 1'b1 || tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstwr_deassert: got wen=%b csn=%b ready=%b expected 1/1/0", WEN, CSN, tx_ready); end
    @(negedge CLK); #1;
    RESET_N = 1'b1;
    wr_base = wr_cnt;
    repeat (15) @(negedge CLK);
    #1;
    n_cmp++; if (wr_cnt !== wr_base || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstwr_quiet: got writes=%0d ready=%b valid=%b expected 0/1/0", wr_cnt - wr_base, tx_ready, rx_valid); end
  endtask

  initial begin
    test_reset();
    test_single_rx();
    test_single_tx();
    test_contention();
    test_fifo_full();
    test_errors();
    test_reset_in_wr();
    n_cmp++; if (proto_err !== 0 || long_strobe !== 0) begin
      n_fail++; $display("FAIL strobe_protocol: got bad=%0d long=%0d expected 0/0", proto_err, long_strobe); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
